// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline hazard logic: memory-handshake state encoding
// and the width helper for the bypass-select buses.
package cpu_types_pkg;

   typedef enum logic {
      MEM_IDLE = 1'b0,
      MEM_WAIT = 1'b1
   } mem_state_t;

   // Bypass select encodes 0 = register file, k = slot k-1, so it needs DEPTH+1 codes.
   function automatic int fwd_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/hazard_slot_match.sv
// Compares one ID-stage source register against every in-flight writer slot and
// reports the youngest match and whether that match is a load-use conflict.
module hazard_slot_match
   import cpu_types_pkg::*;
#(
   parameter int AW    = 5,
   parameter int DEPTH = 3
) (
   input  logic [AW-1:0]             src,
   input  logic [DEPTH-1:0]          valid,
   input  logic [DEPTH-1:0]          load,
   input  logic [DEPTH-1:0][AW-1:0]  wsel,
   output logic                      hit,
   output logic [fwd_width(DEPTH)-1:0] idx,
   output logic                      load_use
);

   localparam int FW = fwd_width(DEPTH);

   logic ld;

   // Scan oldest to youngest so the lowest matching slot index wins.
   always_comb begin
      hit = 1'b0;
      idx = '0;
      ld  = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (valid[i] && (wsel[i] == src) && (src != '0)) begin
            hit = 1'b1;
            idx = FW'(i);
            ld  = load[i];
         end
      end
      load_use = hit & (idx == '0) & ld;
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: tracks in-flight writers, selects operand bypass, and
// arbitrates memory stalls, branch flushes and RAW stalls into latch controls.
//
//   state    | meaning
//   MEM_IDLE | no data-memory request outstanding
//   MEM_WAIT | request issued, waiting for dhit; front of pipe frozen
module hazard_scoreboard
   import cpu_types_pkg::*;
#(
   parameter int NREG       = 32,
   parameter int DEPTH      = 3,
   parameter int FWD_EN     = 1,
   parameter int BR_PENALTY = 1
) (
   input  logic                          CLK,
   input  logic                          nRST,
   input  logic [$clog2(NREG)-1:0]       rsel1_id,
   input  logic [$clog2(NREG)-1:0]       rsel2_id,
   input  logic [$clog2(NREG)-1:0]       wsel_id,
   input  logic                          wen_id,
   input  logic                          load_id,
   input  logic                          dmemREN,
   input  logic                          dmemWEN,
   input  logic                          dhit,
   input  logic                          brtkn_ex,
   output logic                          ifid_en,
   output logic                          idex_en,
   output logic                          exmem_en,
   output logic                          memwb_en,
   output logic                          ifid_sRST,
   output logic                          idex_sRST,
   output logic                          exmem_sRST,
   output logic [fwd_width(DEPTH)-1:0]   fwd1_sel,
   output logic [fwd_width(DEPTH)-1:0]   fwd2_sel,
   output logic [31:0]                   stall_cnt
);

   localparam int         AW  = $clog2(NREG);
   localparam int         FW  = fwd_width(DEPTH);
   localparam logic [1:0] BRP = 2'(BR_PENALTY);

   logic [DEPTH-1:0]          slot_valid;
   logic [DEPTH-1:0]          slot_load;
   logic [DEPTH-1:0][AW-1:0]  slot_wsel;

   mem_state_t mstate, mstate_nxt;
   logic [1:0] fcnt;
   logic       br_pend, br_arm;
   logic       mem_stall, flush, raw_stall, br_eff;
   logic       hit1, hit2, lu1, lu2;
   logic [FW-1:0] idx1, idx2;

   hazard_slot_match #(.AW(AW), .DEPTH(DEPTH)) u_match1 (
      .src(rsel1_id), .valid(slot_valid), .load(slot_load), .wsel(slot_wsel),
      .hit(hit1), .idx(idx1), .load_use(lu1)
   );

   hazard_slot_match #(.AW(AW), .DEPTH(DEPTH)) u_match2 (
      .src(rsel2_id), .valid(slot_valid), .load(slot_load), .wsel(slot_wsel),
      .hit(hit2), .idx(idx2), .load_use(lu2)
   );

   always_comb begin
      mstate_nxt = mstate;
      mem_stall  = 1'b0;
      case (mstate)
         MEM_IDLE: begin
            if ((dmemREN | dmemWEN) & ~dhit) begin
               mstate_nxt = MEM_WAIT;
               mem_stall  = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (dhit) mstate_nxt = MEM_IDLE;
            else      mem_stall  = 1'b1;
         end
         default: mstate_nxt = MEM_IDLE;
      endcase
   end

   // A branch seen during a memory stall is replayed via br_arm once the stall clears.
   always_comb begin
      br_eff     = brtkn_ex | br_arm;
      flush      = br_eff | (fcnt != 2'd0);
      raw_stall  = (FWD_EN != 0) ? (lu1 | lu2) : (hit1 | hit2);
      ifid_en    = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
      ifid_sRST  = 1'b0;
      idex_sRST  = 1'b0;
      exmem_sRST = 1'b0;
      if (!nRST) begin
         if (mem_stall) begin
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
         end else if (flush) begin
            ifid_sRST = 1'b1;
            idex_sRST = 1'b1;
         end else if (raw_stall) begin
            ifid_en   = 1'b0;
            idex_sRST = 1'b1;
         end
      end
      fwd1_sel = (nRST || FWD_EN == 0 || !hit1) ? '0 : idx1 + FW'(1);
      fwd2_sel = (nRST || FWD_EN == 0 || !hit2) ? '0 : idx2 + FW'(1);
   end

   always_ff @(posedge CLK) begin
      if (nRST) begin
         slot_valid <= '0;
         slot_load  <= '0;
         slot_wsel  <= '0;
         mstate     <= MEM_IDLE;
         fcnt       <= 2'd0;
         br_pend    <= 1'b0;
         br_arm     <= 1'b0;
         stall_cnt  <= 32'd0;
      end else begin
         mstate <= mstate_nxt;
         if (idex_en) begin
            slot_valid <= {slot_valid[DEPTH-2:0], wen_id & ~idex_sRST & (wsel_id != '0)};
            slot_load  <= {slot_load[DEPTH-2:0], load_id};
            slot_wsel  <= {slot_wsel[DEPTH-2:0], wsel_id};
         end
         if (mem_stall) begin
            if (brtkn_ex) br_pend <= 1'b1;
         end else begin
            br_pend <= 1'b0;
            br_arm  <= br_pend;
            if (br_eff)              fcnt <= BRP;
            else if (fcnt != 2'd0)   fcnt <= fcnt - 2'd1;
         end
         if (!ifid_en && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: one forwarding instance (BR_PENALTY=2)
// driven from a vector table, one stall-only instance for the no-bypass cases.
module tb_hazard_scoreboard;

   logic       CLK = 1'b0;
   logic       nRST;
   logic [4:0] rsel1_id, rsel2_id, wsel_id;
   logic       wen_id, load_id, dmemREN, dmemWEN, dhit, brtkn_ex;

   logic       ifid_en0, idex_en0, exmem_en0, memwb_en0, ifid_s0, idex_s0, exmem_s0;
   logic [1:0] fwd1_0, fwd2_0;
   logic [31:0] scnt0;
   logic       ifid_en1, idex_en1, exmem_en1, memwb_en1, ifid_s1, idex_s1, exmem_s1;
   logic [1:0] fwd1_1, fwd2_1;
   logic [31:0] scnt1;

   int checks   = 0;
   int failures = 0;

   localparam logic [6:0] NORM = 7'b1111000;
   localparam logic [6:0] LUS  = 7'b0111010;
   localparam logic [6:0] FLSH = 7'b1111110;
   localparam logic [6:0] MEMS = 7'b0001000;

   hazard_scoreboard #(.NREG(32), .DEPTH(3), .FWD_EN(1), .BR_PENALTY(2)) u0 (
      .CLK(CLK), .nRST(nRST), .rsel1_id(rsel1_id), .rsel2_id(rsel2_id),
      .wsel_id(wsel_id), .wen_id(wen_id), .load_id(load_id),
      .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dhit(dhit), .brtkn_ex(brtkn_ex),
      .ifid_en(ifid_en0), .idex_en(idex_en0), .exmem_en(exmem_en0), .memwb_en(memwb_en0),
      .ifid_sRST(ifid_s0), .idex_sRST(idex_s0), .exmem_sRST(exmem_s0),
      .fwd1_sel(fwd1_0), .fwd2_sel(fwd2_0), .stall_cnt(scnt0)
   );

   hazard_scoreboard #(.NREG(32), .DEPTH(3), .FWD_EN(0), .BR_PENALTY(1)) u1 (
      .CLK(CLK), .nRST(nRST), .rsel1_id(rsel1_id), .rsel2_id(rsel2_id),
      .wsel_id(wsel_id), .wen_id(wen_id), .load_id(load_id),
      .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dhit(dhit), .brtkn_ex(brtkn_ex),
      .ifid_en(ifid_en1), .idex_en(idex_en1), .exmem_en(exmem_en1), .memwb_en(memwb_en1),
      .ifid_sRST(ifid_s1), .idex_sRST(idex_s1), .exmem_sRST(exmem_s1),
      .fwd1_sel(fwd1_1), .fwd2_sel(fwd2_1), .stall_cnt(scnt1)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [4:0] r1, r2, w;
      logic       wen, ld, ren, wm, dh, br;
      logic [6:0] ctrl;
      logic [1:0] f1, f2;
   } vec_t;

   vec_t tv [24];

   function automatic vec_t mk(int r1, int r2, int w, bit wen, bit ld, bit ren, bit wm,
                               bit dh, bit br, logic [6:0] c, int f1, int f2);
      vec_t v;
      v.r1 = 5'(r1); v.r2 = 5'(r2); v.w = 5'(w);
      v.wen = wen; v.ld = ld; v.ren = ren; v.wm = wm; v.dh = dh; v.br = br;
      v.ctrl = c; v.f1 = 2'(f1); v.f2 = 2'(f2);
      return v;
   endfunction

   function automatic logic [6:0] ctrl0();
      return {ifid_en0, idex_en0, exmem_en0, memwb_en0, ifid_s0, idex_s0, exmem_s0};
   endfunction

   function automatic logic [6:0] ctrl1();
      return {ifid_en1, idex_en1, exmem_en1, memwb_en1, ifid_s1, idex_s1, exmem_s1};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rsel1_id = v.r1; rsel2_id = v.r2; wsel_id = v.w;
      wen_id = v.wen; load_id = v.ld; dmemREN = v.ren; dmemWEN = v.wm;
      dhit = v.dh; brtkn_ex = v.br;
   endtask

   task automatic idle_in();
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 0));
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
   task automatic to_sample();
      #4;
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      nRST = 1'b1;
      idle_in();
      next_cycle();
      nRST = 1'b0;
   endtask

   initial begin
      tv[0]  = mk(0, 0, 5, 1, 0, 0, 0, 0, 0, NORM, 0, 0);
      tv[1]  = mk(5, 3, 0, 0, 0, 0, 0, 0, 0, NORM, 1, 0);
      tv[2]  = mk(3, 5, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 2);
      tv[3]  = mk(5, 0, 6, 1, 1, 0, 0, 0, 0, NORM, 3, 0);
      tv[4]  = mk(6, 6, 0, 0, 0, 0, 0, 0, 0, LUS,  1, 1);
      tv[5]  = mk(6, 6, 0, 0, 0, 0, 0, 0, 0, NORM, 2, 2);
      tv[6]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, NORM, 0, 0);
      tv[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 0);
      tv[8]  = mk(0, 0, 4, 1, 1, 0, 0, 0, 0, NORM, 0, 0);
      tv[9]  = mk(4, 0, 0, 0, 0, 0, 0, 0, 1, FLSH, 1, 0);
      tv[10] = mk(4, 0, 0, 0, 0, 0, 0, 0, 0, FLSH, 2, 0);
      tv[11] = mk(4, 0, 0, 0, 0, 0, 0, 0, 0, FLSH, 3, 0);
      tv[12] = mk(4, 0, 10, 1, 0, 0, 0, 0, 0, NORM, 0, 0);
      tv[13] = mk(0, 10, 8, 1, 0, 1, 0, 0, 0, MEMS, 0, 1);
      tv[14] = mk(0, 10, 8, 1, 0, 1, 0, 0, 1, MEMS, 0, 1);
      tv[15] = mk(0, 10, 8, 1, 0, 1, 0, 0, 0, MEMS, 0, 1);
      tv[16] = mk(0, 10, 8, 1, 0, 1, 0, 0, 0, MEMS, 0, 1);
      tv[17] = mk(0, 10, 8, 1, 0, 1, 0, 1, 0, NORM, 0, 1);
      tv[18] = mk(8, 10, 0, 0, 0, 0, 0, 0, 0, FLSH, 1, 2);
      tv[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, FLSH, 0, 0);
      tv[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, FLSH, 0, 0);
      tv[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 0);
      tv[22] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, NORM, 0, 0);
      tv[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 0);

      // Reset with hostile inputs: outputs must still read idle.
      nRST = 1'b1;
      drive(mk(5, 5, 5, 1, 1, 1, 0, 0, 1, NORM, 0, 0));
      next_cycle();
      to_sample();
      chk("reset_ctrl_u0", 32'(ctrl0()), 32'(NORM));
      chk("reset_ctrl_u1", 32'(ctrl1()), 32'(NORM));
      chk("reset_fwd_u0", {28'd0, fwd1_0, fwd2_0}, 32'd0);
      next_cycle();
      nRST = 1'b0;
      idle_in();
      to_sample();
      chk("post_reset_ctrl", 32'(ctrl0()), 32'(NORM));
      chk("post_reset_scnt", scnt0, 32'd0);
      next_cycle();

      for (int i = 0; i < 24; i++) begin
         drive(tv[i]);
         to_sample();
         chk($sformatf("vec%0d_ctrl", i), 32'(ctrl0()), 32'(tv[i].ctrl));
         chk($sformatf("vec%0d_fwd1", i), 32'(fwd1_0), 32'(tv[i].f1));
         chk($sformatf("vec%0d_fwd2", i), 32'(fwd2_0), 32'(tv[i].f2));
         if (i == 3) chk("fwd_no_stall_scnt", scnt0, 32'd0);
         next_cycle();
      end
      chk("table_scnt", scnt0, 32'd5);

      // Stall-only instance: writer of r7 then a reader stalls three cycles.
      do_reset();
      drive(mk(0, 0, 7, 1, 0, 0, 0, 0, 0, NORM, 0, 0));
      to_sample();
      chk("nofwd_writer_ctrl", 32'(ctrl1()), 32'(NORM));
      next_cycle();
      for (int k = 0; k < 3; k++) begin
         drive(mk(7, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 0));
         to_sample();
         chk($sformatf("nofwd_stall%0d_ctrl", k), 32'(ctrl1()), 32'(LUS));
         chk($sformatf("nofwd_stall%0d_fwd1", k), 32'(fwd1_1), 32'd0);
         next_cycle();
      end
      to_sample();
      chk("nofwd_release_ctrl", 32'(ctrl1()), 32'(NORM));
      chk("nofwd_scnt", scnt1, 32'd3);
      next_cycle();

      // BR_PENALTY=1 on the stall-only instance: two flush cycles.
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, NORM, 0, 0));
      to_sample();
      chk("brp1_flush0", 32'(ctrl1()), 32'(FLSH));
      next_cycle();
      idle_in();
      to_sample();
      chk("brp1_flush1", 32'(ctrl1()), 32'(FLSH));
      next_cycle();
      to_sample();
      chk("brp1_done", 32'(ctrl1()), 32'(NORM));
      next_cycle();

      // Reset in the middle of a memory wait.
      do_reset();
      drive(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, NORM, 0, 0));
      to_sample();
      chk("wait0_ctrl", 32'(ctrl0()), 32'(MEMS));
      next_cycle();
      to_sample();
      chk("wait1_ctrl", 32'(ctrl0()), 32'(MEMS));
      next_cycle();
      nRST = 1'b1;
      to_sample();
      chk("wait_reset_ctrl", 32'(ctrl0()), 32'(NORM));
      next_cycle();
      nRST = 1'b0;
      idle_in();
      to_sample();
      chk("wait_after_reset_ctrl", 32'(ctrl0()), 32'(NORM));
      chk("wait_after_reset_scnt", scnt0, 32'd0);
      next_cycle();

      // Reset in the middle of a branch flush.
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, NORM, 0, 0));
      to_sample();
      chk("flush_pre_reset", 32'(ctrl0()), 32'(FLSH));
      next_cycle();
      nRST = 1'b1;
      idle_in();
      to_sample();
      chk("flush_reset_ctrl", 32'(ctrl0()), 32'(NORM));
      next_cycle();
      nRST = 1'b0;
      to_sample();
      chk("flush_after_reset_ctrl", 32'(ctrl0()), 32'(NORM));
      next_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NREG, default 32: architectural register count; register 0 is hardwired zero.
REQ-002 Parameter DEPTH, default 3: number of in-flight writer slots tracked (EX, MEM, WB order), legal range 2..6.
REQ-003 Parameter FWD_EN, default 1: 1 enables forwarding (operand bypass); 0 gives stall-only resolution.
REQ-004 Parameter BR_PENALTY, default 1: number of flush cycles after a taken branch, legal range 1..3.
REQ-005 Port CLK  in  1  system clock; all state updates on its rising edge.
REQ-006 Port nRST  in  1  synchronous, active-high reset, sampled on the CLK rising edge.
REQ-007 Ports rsel1_id, rsel2_id  in  clog2(NREG) each  ID-stage source registers.
REQ-008 Ports wsel_id  in  clog2(NREG), wen_id  in  1, load_id  in  1  ID-stage destination, write enable, and load flag.
REQ-009 Ports dmemREN, dmemWEN  in  1, dhit  in  1  MEM-stage data request and completion.
REQ-010 Ports brtkn_ex  in  1  taken branch/jump resolved in EX.
REQ-011 Ports ifid_en, idex_en, exmem_en, memwb_en  out  1  latch enables; ifid_sRST, idex_sRST, exmem_sRST  out  1  latch flushes.
REQ-012 Ports fwd1_sel, fwd2_sel  out  clog2(DEPTH+1)  bypass source: 0 = register file, k = slot k-1.
REQ-013 Port stall_cnt  out  32  saturating count of cycles with ifid_en=0.

Function
REQ-014 The scoreboard SHALL hold DEPTH slots {valid, wsel, load}; slot 0 is EX, slot DEPTH-1 is the oldest.
REQ-015 When idex_en=1, slots SHALL shift by one, and slot 0 SHALL load {wen_id & ~idex_sRST & wsel_id!=0, wsel_id, load_id}.
REQ-016 When idex_en=0 (memory stall), the slots SHALL hold their values.
REQ-017 A RAW hazard SHALL exist for a source r!=0 when any valid slot has wsel==r.
REQ-018 With FWD_EN=0, any RAW hazard SHALL stall: ifid_en=0, idex_sRST=1, and the slots SHALL shift with a bubble in slot 0.
REQ-019 With FWD_EN=1, a hazard SHALL stall only if the youngest matching slot is slot 0 and has load=1 (load-use); otherwise fwdN_sel SHALL equal the youngest matching slot index+1.
REQ-020 fwdN_sel SHALL be 0 when there is no match, when the source is register 0, or when FWD_EN=0.
REQ-021 The memory FSM SHALL have states IDLE and WAIT; it moves IDLE->WAIT on (dmemREN|dmemWEN)&~dhit, and WAIT->IDLE on dhit.
REQ-022 While a request is pending without dhit, ifid_en, idex_en and exmem_en SHALL be 0, with memwb_en=1 and memwb fed a bubble via exmem_sRST=0 hold.
REQ-023 In the dhit cycle, all enables SHALL be 1 and exmem_sRST SHALL be 0.
REQ-024 brtkn_ex SHALL load a flush counter with BR_PENALTY; while it is nonzero or brtkn_ex=1, ifid_sRST=1 and idex_sRST=1, and the counter decrements each enabled cycle.
REQ-025 Priority SHALL be memory stall > branch flush > RAW stall; a flush cancels a concurrent RAW stall.
REQ-026 brtkn_ex during a memory stall SHALL be captured and applied on the first cycle after the stall ends.
REQ-027 stall_cnt SHALL increment when ifid_en=0 and saturate at 0xFFFF_FFFF.
REQ-028 All enable/flush outputs SHALL be combinational from current state and inputs; latency from a hazard input to its stall output SHALL be 0 cycles.

Reset
REQ-029 On nRST=1, all slots SHALL be invalid, the FSM SHALL be IDLE, the flush counter and stall_cnt SHALL be 0.
REQ-030 During reset, outputs SHALL read: all enables 1, all sRST 0, fwd sel 0.
REQ-031 Reset during WAIT or during a flush SHALL abandon it with no residual stall.

Structure
REQ-032 The memory-FSM state enum and the fwd-select width function SHALL live in cpu_types_pkg.
REQ-033 One sub-module, hazard_slot_match, SHALL compare one source against all slots and return {hit, youngest index, load-use}; it is instantiated twice.

Verification
REQ-034 FWD_EN=1: ADD writing r5, then a reader of r5 next cycle -> fwd1_sel=1, no stall, stall_cnt unchanged.
REQ-035 FWD_EN=1: LW writing r5, then a reader of r5 -> one-cycle stall (ifid_en=0, idex_sRST=1), then fwd1_sel=2.
REQ-036 FWD_EN=0, DEPTH=3: writer of r7, then a reader of r7 -> three stall cycles, stall_cnt=3.
REQ-037 dmemREN with dhit delayed 4 cycles -> ifid/idex/exmem_en=0 for 4 cycles, then all 1; slots unchanged across the stall.
REQ-038 BR_PENALTY=2: brtkn_ex pulse -> ifid_sRST=idex_sRST=1 for 3 cycles; brtkn_ex in a WAIT cycle -> flush begins after dhit.
REQ-039 Writer of r0, then a reader of r0 -> no stall and fwd sel 0; nRST asserted mid-WAIT -> enables 1 on the next cycle.
